// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response and decode handshake.
// master = fetch unit side, slave = memory/decode side.
interface if_fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues imem reads for pc, tracks in-flight PCs,
// buffers {pc,instr} for decode, stalls PC, flushes on jump_flag.
// Ports: clk, reset (sync, high), pc, jump_flag, fetch_stall, bus.
module if_fetch_unit #(
  parameter int              XLEN  = 32,
  parameter int              ILEN  = 32,
  parameter int              DEPTH = 2,
  parameter logic [ILEN-1:0] NOP   = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            jump_flag,
  output logic            fetch_stall,
  if_fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] trk_pc  [DEPTH];
  logic [XLEN-1:0] buf_pc  [DEPTH];
  logic [ILEN-1:0] buf_ins [DEPTH];

  logic [AW-1:0] trk_wr, trk_rd;
  logic [AW-1:0] buf_wr, buf_rd;

  logic [CW-1:0] inflight, inflight_n;
  logic [CW-1:0] drop, drop_n;
  logic [CW-1:0] buf_count, buf_count_n;
  logic [CW:0]   occ;

  logic credit, issue;
  logic rsp_pop, rsp_drop, rsp_keep;
  logic id_pop;

  // Credit looks at registered occupancy only: a
  // same-cycle pop never frees a slot for an issue.
  assign occ    = {1'b0, inflight} + {1'b0, buf_count};
  assign credit = occ < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = !reset && !jump_flag
                           && credit;
  assign bus.imem_req_addr  = pc;

  assign issue       = bus.imem_req_valid
                    && bus.imem_req_ready;
  assign fetch_stall = !issue;

  // Every response with something in flight pops the
  // tracker; it is buffered only if it is right-path
  // and no flush is happening this cycle.
  assign rsp_pop  = bus.imem_rsp_valid
                 && (inflight != '0);
  assign rsp_drop = rsp_pop && (drop != '0);
  assign rsp_keep = rsp_pop && (drop == '0)
                 && !jump_flag;

  assign bus.id_valid = buf_count != '0;
  assign id_pop = bus.id_valid && bus.id_ready
               && !jump_flag;

  assign bus.id_pc    = bus.id_valid
                      ? buf_pc[buf_rd] : '0;
  assign bus.id_instr = bus.id_valid
                      ? buf_ins[buf_rd] : NOP;

  always_comb begin
    inflight_n  = inflight + CW'(issue)
                - CW'(rsp_pop);
    drop_n      = drop;
    buf_count_n = buf_count + CW'(rsp_keep)
                - CW'(id_pop);
    unique case (1'b1)
      jump_flag: begin
        // Everything still outstanding is wrong-path.
        drop_n      = inflight_n;
        buf_count_n = '0;
      end
      (rsp_drop && !jump_flag): begin
        drop_n = drop - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight  <= '0;
      drop      <= '0;
      buf_count <= '0;
      trk_wr    <= '0;
      trk_rd    <= '0;
      buf_wr    <= '0;
      buf_rd    <= '0;
    end else begin
      inflight  <= inflight_n;
      drop      <= drop_n;
      buf_count <= buf_count_n;
      trk_wr    <= trk_wr + AW'(issue);
      trk_rd    <= trk_rd + AW'(rsp_pop);
      if (jump_flag) begin
        buf_wr <= '0;
        buf_rd <= '0;
      end else begin
        buf_wr <= buf_wr + AW'(rsp_keep);
        buf_rd <= buf_rd + AW'(id_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      trk_pc[trk_wr] <= pc;
    if (rsp_keep) begin
      buf_pc[buf_wr]  <= trk_pc[trk_rd];
      buf_ins[buf_wr] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: PC register and imem models,
// expected {pc,instr} queue popped by a decode-side monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        jump_flag = 1'b0;
  logic        fetch_stall;

  if_fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .jump_flag   (jump_flag),
    .fetch_stall (fetch_stall),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  int          lat = 1;
  int          issued = 0;
  logic [31:0] lim = '0;
  logic [31:0] tgt = '0;
  logic        tog = 1'b0;

  function automatic logic [31:0] md(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_t e;
    e.pc  = p;
    e.ins = md(p);
    exp_q.push_back(e);
  endtask

  task automatic upd_ready();
    bus.imem_req_ready = (tog ? (cyc % 2 == 0) : 1'b1)
                      && (pc < lim);
  endtask

  task automatic tick();
    logic        iss;
    logic        st;
    logic [31:0] a;
    mreq_t       m;
    @(negedge clk);
    iss = bus.imem_req_valid & bus.imem_req_ready;
    st  = fetch_stall;
    a   = bus.imem_req_addr;
    if (bus.imem_req_valid)
      chk("req_addr", a, pc);
    if (tog && bus.imem_req_valid)
      chk("stall_vs_ready", 32'(fetch_stall),
          32'(!bus.imem_req_ready));
    @(posedge clk);
    #1;
    cyc++;
    if (jump_flag) pc = tgt;
    else if (!st) pc = pc + 32'd4;
    if (iss) begin
      issued++;
      m.a   = a;
      m.due = cyc + lat - 1;
      mem_q.push_back(m);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = md(m.a);
    end
    upd_ready();
  endtask

  task automatic do_reset(input logic [31:0] base);
    reset     = 1'b1;
    jump_flag = 1'b0;
    pc        = base;
    mem_q.delete();
    bus.imem_rsp_valid = 1'b0;
    upd_ready();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_id_valid", 32'(bus.id_valid), 0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_id_pc", bus.id_pc, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    tick();
    tick();
    chk("idle_id_valid", 32'(bus.id_valid), 0);
  endtask

  // Decode-side monitor: every accepted instruction is
  // checked against the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_pop: got pc %h want none",
                 bus.id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_instr", bus.id_instr, e.ins);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (int'(dut.inflight) + int'(dut.buf_count) <= 2)
      else begin
        nmis++;
        $display("FAIL inv_occ: got %0d want <=2",
                 int'(dut.inflight) + int'(dut.buf_count));
      end
      assert (dut.drop <= dut.inflight)
      else begin
        nmis++;
        $display("FAIL inv_drop: got %0d want <=%0d",
                 dut.drop, dut.inflight);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b1;

    // Streaming, 1-cycle memory, two-cycle first latency.
    lat = 1;
    lim = 32'd12;
    do_reset(32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    tick();
    chk("lat_c1_valid", 32'(bus.id_valid), 0);
    tick();
    chk("lat_c2_valid", 32'(bus.id_valid), 1);
    chk("lat_c2_pc", bus.id_pc, 32'h0);
    drain();

    // Decode stalled: only DEPTH requests go out.
    bus.id_ready = 1'b0;
    lim = 32'hFFFF;
    do_reset(32'h0);
    issued = 0;
    repeat (6) tick();
    chk("bp_issued", issued, 2);
    chk("bp_stall", 32'(fetch_stall), 1);
    chk("bp_pc", pc, 32'h8);
    chk("bp_head_pc", bus.id_pc, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    lim = 32'd12;
    bus.id_ready = 1'b1;
    upd_ready();
    drain();

    // Flush with two slow requests outstanding.
    lat = 3;
    lim = 32'd16;
    do_reset(32'h8);
    tick();
    tick();
    jump_flag = 1'b1;
    tgt = 32'h100;
    lim = 32'h104;
    upd_ready();
    chk("flush_noreq", 32'(bus.imem_req_valid), 0);
    issued = 0;
    tick();
    jump_flag = 1'b0;
    chk("flush_issued", issued, 0);
    chk("flush_pc", pc, 32'h100);
    expect_pc(32'h100);
    drain();

    // Flush while buffered and a response lands.
    lat = 1;
    lim = 32'h28;
    bus.id_ready = 1'b0;
    do_reset(32'h20);
    tick();
    tick();
    chk("hold_valid", 32'(bus.id_valid), 1);
    chk("hold_pc", bus.id_pc, 32'h20);
    jump_flag = 1'b1;
    tgt = 32'h200;
    lim = 32'h204;
    upd_ready();
    tick();
    jump_flag = 1'b0;
    chk("flushbuf_valid", 32'(bus.id_valid), 0);
    chk("flushbuf_instr", bus.id_instr, NOP);
    expect_pc(32'h200);
    bus.id_ready = 1'b1;
    drain();

    // Request ready toggling every cycle.
    lat = 1;
    tog = 1'b1;
    lim = 32'h50;
    do_reset(32'h40);
    expect_pc(32'h40);
    expect_pc(32'h44);
    expect_pc(32'h48);
    expect_pc(32'h4c);
    drain();
    tog = 1'b0;

    // Reset mid-stream, then a stray response.
    lat = 3;
    lim = 32'h88;
    do_reset(32'h80);
    tick();
    tick();
    lim = 32'h300;
    do_reset(32'h300);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEADBEEF;
    tick();
    chk("stray_valid", 32'(bus.id_valid), 0);
    chk("stray_instr", bus.id_instr, NOP);
    chk("stray_pc", bus.id_pc, 32'h0);
    chk("stray_credit", 32'(bus.imem_req_valid), 1);
    tick();
    chk("stray_valid2", 32'(bus.id_valid), 0);
    lim = 32'h304;
    upd_ready();
    expect_pc(32'h300);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
